// File: rtl/noc_buf_pkg.sv
// Shared NoC buffer constants and receive-FSM state encoding.
package noc_buf_pkg;
    localparam int FLIT_W  = 20;
    localparam int PKT_LEN = 30;
    localparam int ADDR_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/datain_buf_ram.sv
// Packet storage: one write port, one registered read-first read port.
// The array itself is never reset; only the read register is.
module datain_buf_ram #(
    parameter int W     = 20,
    parameter int DEPTH = 30,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Reads see the pre-write contents; out-of-range addresses return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_rdata <= '0;
        else if (i_raddr < LIMIT)  r_rdata <= r_mem[i_raddr];
        else                       r_rdata <= '0;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/datain_buf.sv
// Receive sink: captures one PKT_LEN-flit packet from the NoC for readback.
// Optional running XOR checksum enabled by DATAIN_BUF_CHECKSUM_EN.
module datain_buf #(
    parameter int FLIT_W  = noc_buf_pkg::FLIT_W,
    parameter int PKT_LEN = noc_buf_pkg::PKT_LEN,
    parameter int ADDR_W  = noc_buf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              enable,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [FLIT_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rx_count,
    output logic              done,
    output logic              overflow,
    output logic [FLIT_W-1:0] checksum
);
    import noc_buf_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PKT_LEN - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr, r_rx_count;
    logic              r_done, r_overflow;
    logic              w_acc, w_last;

    assign w_acc  = enable && in_valid && (r_state != DONE) && !clr;
    assign w_last = w_acc && (r_rx_count == LAST);

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, RECV: if (w_acc) w_state_nxt = w_last ? DONE : RECV;
                DONE:       w_state_nxt = DONE;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Write pointer parks on the last slot so it never leaves the array.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_wr_addr  <= '0;
            r_rx_count <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_addr  <= '0;
            r_rx_count <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_acc) begin
                r_rx_count <= r_rx_count + 1'b1;
                if (!w_last) r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (w_last) r_done <= 1'b1;
            if ((r_state == DONE) && enable && in_valid) r_overflow <= 1'b1;
        end
    end

`ifdef DATAIN_BUF_CHECKSUM_EN
    logic [FLIT_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST)       r_checksum <= '0;
        else if (clr)   r_checksum <= '0;
        else if (w_acc) r_checksum <= r_checksum ^ datain;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    datain_buf_ram #(
        .W     (FLIT_W),
        .DEPTH (PKT_LEN),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (RST),
        .i_we    (w_acc),
        .i_waddr (r_wr_addr),
        .i_wdata (datain),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign rx_count = r_rx_count;
    assign done     = r_done;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_datain_buf.sv
// Self-checking bench for datain_buf against a packet-level reference model.
module tb_datain_buf;
    localparam int FW = 20;
    localparam int PL = 30;

    logic          clk = 1'b0;
    logic          RST = 1'b0;
    logic          enable = 1'b0, in_valid = 1'b0, clr = 1'b0;
    logic [FW-1:0] datain = '0;
    logic [4:0]    rd_addr = '0;
    logic [FW-1:0] rd_data, checksum;
    logic [4:0]    rx_count;
    logic          done, overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: captured flits, count, flags, checksum.
    logic [FW-1:0] m_mem [PL];
    bit            m_known [PL];
    int            m_cnt;
    bit            m_done, m_ovf;
    logic [FW-1:0] m_ck;

    always #5 clk = ~clk;

    datain_buf dut (
        .clk      (clk),
        .RST      (RST),
        .enable   (enable),
        .datain   (datain),
        .in_valid (in_valid),
        .clr      (clr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rx_count (rx_count),
        .done     (done),
        .overflow (overflow),
        .checksum (checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_ck_of(input logic [FW-1:0] v);
`ifdef DATAIN_BUF_CHECKSUM_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_done = 0; m_ovf = 0; m_ck = '0;
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input bit en, input bit vld, input logic [FW-1:0] d,
                       input bit c, input logic [4:0] ra);
        logic [FW-1:0] erd;
        bit            rdk;
        enable = en; in_valid = vld; datain = d; clr = c; rd_addr = ra;
        @(posedge clk);
        if (int'(ra) >= PL) begin erd = '0; rdk = 1; end
        else begin erd = m_mem[ra]; rdk = m_known[ra]; end
        if (c) begin
            model_clear();
        end else if (en && vld) begin
            if (m_done) m_ovf = 1;
            else begin
                m_mem[m_cnt] = d; m_known[m_cnt] = 1;
                m_cnt++;
                m_ck = m_ck ^ exp_ck_of(d);
                if (m_cnt == PL) m_done = 1;
            end
        end
        @(negedge clk);
        chk("rx_count", 32'(rx_count), 32'(m_cnt));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("checksum", 32'(checksum), 32'(m_ck));
        if (rdk) chk("rd_data", 32'(rd_data), 32'(erd));
    endtask

    task automatic do_reset();
        #2 RST = 1'b0;
        #1;
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ck", 32'(checksum), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        model_clear();
        for (int k = 0; k < PL; k++) m_known[k] = 0;
        @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic readback();
        for (int a = 0; a < 32; a++) cyc(0, 0, '0, 0, 5'(a));
    endtask

    function automatic logic [4:0] ra_rnd();
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int k = 0; k < PL; k++) m_known[k] = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Back-to-back packet of ascending values.
        for (int i = 0; i < PL; i++) cyc(1, 1, FW'(i), 0, ra_rnd());
        chk("done_at_30", 32'(done), 32'd1);
        chk("count_30", 32'(rx_count), 32'd30);
        readback();
        cyc(0, 0, '0, 0, 5'd7);
        chk("rd_addr7", 32'(rd_data), 32'd7);

        // Overflow after done; mem[29] must survive.
        cyc(1, 1, 20'hFFFFF, 0, 5'd29);
        cyc(1, 1, 20'hFFFFF, 0, 5'd29);
        cyc(0, 0, '0, 0, 5'd29);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("mem29_kept", 32'(rd_data), 32'd29);
        chk("count_sat", 32'(rx_count), 32'd30);
        cyc(1, 1, 20'hFFFFF, 1, 5'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_done", 32'(done), 32'd0);

        // Same packet with valid gaps and an enable pause at flit 12.
        for (int i = 0; i < PL; i++) begin
            if (i == 12) begin
                for (int p = 0; p < 5; p++) begin
                    cyc(0, 1, FW'($urandom), 0, ra_rnd());
                    chk("pause_hold", 32'(rx_count), 32'd12);
                end
            end
            cyc(1, 1, FW'(i), 0, ra_rnd());
            if (i < PL - 1) begin
                chk("no_early_done", 32'(done), 32'd0);
                repeat ($urandom_range(1, 3)) cyc(1, 0, FW'($urandom), 0, ra_rnd());
            end
        end
        chk("gap_done", 32'(done), 32'd1);
        readback();

        // Reset mid-packet, then a fresh packet.
        cyc(0, 0, '0, 1, 5'd0);
        for (int i = 0; i < 17; i++) cyc(1, 1, FW'($urandom), 0, ra_rnd());
        do_reset();
        for (int i = 0; i < PL; i++) cyc(1, 1, 20'hA5A5A, 0, ra_rnd());
        chk("a5_count", 32'(rx_count), 32'd30);
        readback();
        cyc(0, 0, '0, 0, 5'd0);
        chk("a5_addr0", 32'(rd_data), 32'hA5A5A);

        // clr collides with a valid flit at count 4.
        cyc(0, 0, '0, 1, 5'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, FW'($urandom), 0, ra_rnd());
        cyc(1, 1, 20'hABCDE, 1, 5'd0);
        chk("clr_prio", 32'(rx_count), 32'd0);
        cyc(1, 1, 20'h12345, 0, 5'd31);
        cyc(0, 0, '0, 0, 5'd0);
        chk("after_clr_addr0", 32'(rd_data), 32'h12345);

        // Checksum over 1..30.
        cyc(0, 0, '0, 1, 5'd0);
        for (int i = 1; i <= PL; i++) cyc(1, 1, FW'(i), 0, ra_rnd());
`ifdef DATAIN_BUF_CHECKSUM_EN
        chk("ck_1to30", 32'(checksum), 32'h1F);
`else
        chk("ck_off", 32'(checksum), 32'h0);
`endif
        cyc(1, 1, 20'h55555, 0, 5'd0);
        cyc(0, 0, '0, 1, 5'd0);
        chk("ck_clr", 32'(checksum), 32'h0);

        // Random traffic with occasional clr.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                FW'($urandom), ($urandom_range(0, 79) == 0), ra_rnd());
        end
        readback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
